puf_challenge_seq: RTL and testbench
====================================

# puf_challenge_seq

Challenge sequencer and response collector for the ring-oscillator PUF. It drives the oscillator-select and enable inputs of the two oscillator/counter banks and clears their counters. For each challenge it runs a fixed measurement window, then compares the two 8-bit counts and assembles the per-challenge bits into a RESP_BITS-wide response word with a valid strobe. It sits directly downstream of the counter banks and replaces the combinational count comparator.

## Interface
- WINDOW, 16: clk cycles the oscillators are enabled per challenge; legal range 1..65535.
- RESP_BITS, 8: response bits per run, one per challenge; legal range 1..32.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset rst_n, asynchronous, active-high.
- start  in  1  sampled only in IDLE; high begins a run.
- challenge  in  5  first oscillator index; captured on the start edge.
- count_a  in  8  bank A counter value.
- count_b  in  8  bank B counter value.
- sel  out  5  oscillator select to both bank muxes.
- osc_en  out  1  oscillator enable to both banks.
- cnt_clr  out  1  counter clear to both banks, active-high.
- busy  out  1  high from CLEAR through DONE.
- resp  out  RESP_BITS  response word.
- resp_valid  out  1  one-cycle strobe; resp is complete.
- tie_mask  out  RESP_BITS  per-bit equal-count flags; see Configuration.

## Operation
- Reset values of all outputs: sel=0, osc_en=0, cnt_clr=0, busy=0, resp=0, resp_valid=0, tie_mask=0. Internal state resets to IDLE, the bit index to 0 and the window counter to 0.
- FSM states:
  - IDLE: wait for start. On start: capture challenge into sel, clear resp and tie_mask, set bit index to 0, go to CLEAR.
  - CLEAR: one cycle; cnt_clr=1, osc_en=0; go to RUN.
  - RUN: WINDOW cycles; osc_en=1; the window counter counts 0..WINDOW-1; then go to SETTLE.
  - SETTLE: 2 cycles; osc_en=0, so the asynchronous counters stop and settle before the counts are sampled; go to COMPARE.
  - COMPARE: one cycle.
    - Compute resp[idx] = (count_a > count_b) as an unsigned 8-bit comparison; equal counts give 0.
    - Increment sel modulo 32, so 31 wraps to 0.
    - If idx == RESP_BITS-1, go to DONE. Otherwise increment idx and go to CLEAR.
  - DONE: one cycle; resp_valid=1; go to IDLE.
- Bit order: the first challenge produces resp[0] and the last produces resp[RESP_BITS-1].
- resp and tie_mask hold their values after DONE until the next start or reset.
- start while busy is ignored; no queuing. start held high continuously restarts immediately after DONE→IDLE (one IDLE cycle between runs).
- Counts are used only in COMPARE; count_a/count_b values in other states are don't-care.
- Counter wrap inside the window is not detected; WINDOW must be sized so that 8-bit counts do not wrap.

## Timing
- Let the edge that samples start be edge 0.
- Cycle 1 is the first CLEAR cycle.
- Each bit takes exactly WINDOW+4 cycles (CLEAR 1, RUN WINDOW, SETTLE 2, COMPARE 1).
- resp_valid is high during cycle RESP_BITS·(WINDOW+4)+1 only. With the defaults this is cycle 161.
- busy is high during cycles 1 through RESP_BITS·(WINDOW+4)+1 inclusive.
- sel changes on the edge that ends COMPARE and is stable throughout the next CLEAR/RUN.
- osc_en and cnt_clr are registered outputs with no glitches and are never high together.
- Reset mid-operation forces all outputs to their reset values asynchronously, including osc_en=0 without waiting for a clock edge. The partial response is discarded.

## Configuration
- PUF_TIE_MASK_EN defined: in COMPARE, tie_mask[idx] = (count_a == count_b); tie_mask is cleared on start.
- PUF_TIE_MASK_EN undefined: the tie_mask port remains but is tied to 0, and no comparator or register is built for it.
- resp behaviour is identical in both cases.

## Test plan
- Reset behaviour: assert rst_n for 3 cycles, release with start=0 → all outputs 0, busy stays 0 for 50 cycles.
- Basic run: WINDOW=16, RESP_BITS=8, challenge=5, bench drives count_a=100, count_b=50 → sel steps 5..12, resp=0xFF, resp_valid high only in cycle 161, busy low in cycle 162.
- Wrap and bit order: challenge=30, bench returns a>b only when sel is even → sel sequence 30,31,0,1,2,3,4,5 and resp=0x55.
- Equal counts: count_a=count_b=77 → resp=0x00; tie_mask=0xFF with PUF_TIE_MASK_EN defined, 0x00 without it.
- Busy restart rules: start pulsed at cycle 40 of a run → ignored, resp_valid still at cycle 161. start after DONE → resp reads 0 from cycle 1 of the new run.
- Reset mid-run: assert rst_n during RUN of bit 3 → osc_en drops before the next clk edge, busy=0, resp=0. The next start runs a full, correct sequence.

Source files
------------

// File: rtl/puf_challenge_seq_if.sv
// Handshake and bank-control bundle between the PUF challenge sequencer and its
// requester / oscillator-counter banks.
interface puf_challenge_seq_if #(
    parameter int RESP_BITS = 8
);
    logic                 start;
    logic [4:0]           challenge;
    logic [7:0]           count_a;
    logic [7:0]           count_b;
    logic [4:0]           sel;
    logic                 osc_en;
    logic                 cnt_clr;
    logic                 busy;
    logic [RESP_BITS-1:0] resp;
    logic                 resp_valid;
    logic [RESP_BITS-1:0] tie_mask;

    // requester side: issues runs, returns bank counts, consumes the response
    modport master (
        output start, challenge, count_a, count_b,
        input  sel, osc_en, cnt_clr, busy, resp, resp_valid, tie_mask
    );

    // sequencer side
    modport slave (
        input  start, challenge, count_a, count_b,
        output sel, osc_en, cnt_clr, busy, resp, resp_valid, tie_mask
    );
endinterface

// File: rtl/puf_challenge_seq.sv
// Ring-oscillator PUF challenge sequencer: per challenge clears, enables, settles and
// compares the two bank counts. Optional tie flags built when PUF_TIE_MASK_EN is defined.
module puf_challenge_seq #(
    parameter int WINDOW    = 16,
    parameter int RESP_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    puf_challenge_seq_if.slave bus
);
    localparam int          IDX_W       = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [15:0] WIN_LAST    = 16'(WINDOW - 1);
    localparam logic [15:0] SETTLE_LAST = 16'd1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        SETTLE  = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           sel_q, sel_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [15:0]          win_q, win_d;
    logic [RESP_BITS-1:0] resp_q, resp_d;
    logic                 osc_en_q, osc_en_d;
    logic                 cnt_clr_q, cnt_clr_d;
    logic                 busy_q, busy_d;
    logic                 resp_valid_q, resp_valid_d;
`ifdef PUF_TIE_MASK_EN
    logic [RESP_BITS-1:0] tie_q, tie_d;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        win_d   = win_q;
        resp_d  = resp_q;
`ifdef PUF_TIE_MASK_EN
        tie_d   = tie_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sel_d   = bus.challenge;
                    resp_d  = '0;
`ifdef PUF_TIE_MASK_EN
                    tie_d   = '0;
`endif
                    idx_d   = '0;
                    win_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                win_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (win_q == WIN_LAST) begin
                    win_d   = '0;
                    state_d = SETTLE;
                end else begin
                    win_d = win_q + 16'd1;
                end
            end
            // window counter is reused to time the two settle cycles
            SETTLE: begin
                if (win_q == SETTLE_LAST) begin
                    win_d   = '0;
                    state_d = COMPARE;
                end else begin
                    win_d = win_q + 16'd1;
                end
            end
            COMPARE: begin
                resp_d[idx_q] = (bus.count_a > bus.count_b);
`ifdef PUF_TIE_MASK_EN
                tie_d[idx_q]  = (bus.count_a == bus.count_b);
`endif
                sel_d = sel_q + 5'd1;
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = CLEAR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // outputs are decoded from the next state so they come straight off flops
        osc_en_d     = (state_d == RUN);
        cnt_clr_d    = (state_d == CLEAR);
        busy_d       = (state_d != IDLE);
        resp_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            idx_q        <= '0;
            win_q        <= '0;
            resp_q       <= '0;
            osc_en_q     <= 1'b0;
            cnt_clr_q    <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
`ifdef PUF_TIE_MASK_EN
            tie_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            idx_q        <= idx_d;
            win_q        <= win_d;
            resp_q       <= resp_d;
            osc_en_q     <= osc_en_d;
            cnt_clr_q    <= cnt_clr_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
`ifdef PUF_TIE_MASK_EN
            tie_q        <= tie_d;
`endif
        end
    end

    assign bus.sel        = sel_q;
    assign bus.osc_en     = osc_en_q;
    assign bus.cnt_clr    = cnt_clr_q;
    assign bus.busy       = busy_q;
    assign bus.resp       = resp_q;
    assign bus.resp_valid = resp_valid_q;
`ifdef PUF_TIE_MASK_EN
    assign bus.tie_mask   = tie_q;
`else
    assign bus.tie_mask   = '0;
`endif
endmodule

// File: tb/tb_puf_challenge_seq.sv
// Randomized bench for puf_challenge_seq: counts come from per-oscillator tables, and
// the expected response is derived from the challenge walk over those tables.
module tb_puf_challenge_seq;
    localparam int W  = 16;
    localparam int RB = 8;
    localparam int BIT_CYC = W + 4;
    localparam int T  = RB * BIT_CYC;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [7:0] ca_tab [32];
    logic [7:0] cb_tab [32];

    puf_challenge_seq_if #(.RESP_BITS(RB)) bus ();

    puf_challenge_seq #(.WINDOW(W), .RESP_BITS(RB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // the banks answer with whatever the table holds for the currently selected oscillator
    initial begin
        bus.count_a = 8'd0;
        bus.count_b = 8'd0;
        forever begin
            @(posedge clk);
            #1;
            bus.count_a = ca_tab[bus.sel];
            bus.count_b = cb_tab[bus.sel];
        end
    end

    task automatic fill_const(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 32; i++) begin
            ca_tab[i] = a;
            cb_tab[i] = b;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            ca_tab[i] = 8'($urandom_range(0, 7));
            cb_tab[i] = 8'($urandom_range(0, 7));
        end
    endtask

    task automatic do_run(input logic [4:0] ch, input int pulse_at, input bit hold);
        logic [RB-1:0] er;
        logic [RB-1:0] et;
        int s;
        for (int i = 0; i < RB; i++) begin
            s = (int'(ch) + i) % 32;
            er[i] = (ca_tab[s] > cb_tab[s]);
`ifdef PUF_TIE_MASK_EN
            et[i] = (ca_tab[s] == cb_tab[s]);
`else
            et[i] = 1'b0;
`endif
        end
        @(negedge clk);
        bus.start     = 1'b1;
        bus.challenge = ch;
        @(posedge clk);
        #1;
        for (int c = 1; c <= T + 1; c++) begin
            if (c == pulse_at || hold) bus.start = 1'b1;
            else bus.start = 1'b0;
            chk("busy", 32'(bus.busy), 32'd1);
            chk("resp_valid", 32'(bus.resp_valid), 32'(c == T + 1));
            chk("en_clr_excl", 32'(bus.osc_en & bus.cnt_clr), 32'd0);
            if (c == 1) begin
                chk("resp_cleared", 32'(bus.resp), 32'd0);
                chk("tie_cleared", 32'(bus.tie_mask), 32'd0);
            end
            if (c <= T && (c - 1) % BIT_CYC == 0) begin
                chk("sel", 32'(bus.sel), 32'((int'(ch) + (c - 1) / BIT_CYC) % 32));
                chk("cnt_clr", 32'(bus.cnt_clr), 32'd1);
            end
            if (c <= T && (c - 2) % BIT_CYC == 0)
                chk("osc_en_run", 32'(bus.osc_en), 32'd1);
            if (c <= T && (c % BIT_CYC == 0 || (c + 1) % BIT_CYC == 0))
                chk("osc_en_settle", 32'(bus.osc_en), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("busy_after", 32'(bus.busy), 32'd0);
        chk("valid_after", 32'(bus.resp_valid), 32'd0);
        chk("resp", 32'(bus.resp), 32'(er));
        chk("tie_mask", 32'(bus.tie_mask), 32'(et));
        if (hold) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            chk("restart_busy", 32'(bus.busy), 32'd1);
            chk("restart_clr", 32'(bus.cnt_clr), 32'd1);
            chk("restart_resp", 32'(bus.resp), 32'd0);
            repeat (T + 2) @(posedge clk);
            #1;
            chk("restart_done", 32'(bus.busy), 32'd0);
        end
        bus.start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_sel"}, 32'(bus.sel), 32'd0);
        chk({tag, "_osc_en"}, 32'(bus.osc_en), 32'd0);
        chk({tag, "_cnt_clr"}, 32'(bus.cnt_clr), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_resp"}, 32'(bus.resp), 32'd0);
        chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_tie"}, 32'(bus.tie_mask), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        bus.start = 1'b0;
        bus.challenge = 5'd0;
        fill_const(8'd0, 8'd0);

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end
        check_idle_outputs("post_reset");

        fill_const(8'd100, 8'd50);
        do_run(5'd5, 0, 1'b0);

        for (int i = 0; i < 32; i++) begin
            ca_tab[i] = (i % 2 == 0) ? 8'd9 : 8'd3;
            cb_tab[i] = 8'd5;
        end
        do_run(5'd30, 0, 1'b0);

        fill_const(8'd77, 8'd77);
        do_run(5'd12, 0, 1'b0);

        fill_const(8'd100, 8'd50);
        do_run(5'd0, 40, 1'b0);
        fill_random();
        do_run(5'd17, 0, 1'b1);

        fill_random();
        @(negedge clk);
        bus.start = 1'b1;
        bus.challenge = 5'($urandom_range(0, 31));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3 * BIT_CYC + 4) @(posedge clk);
        #1;
        chk("pre_reset_osc_en", 32'(bus.osc_en), 32'd1);
        #3;
        rst_n = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        do_run(5'($urandom_range(0, 31)), 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            fill_random();
            do_run(5'($urandom_range(0, 31)), 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
